// File: rtl/jtag_debug_host_scan.sv
// Initiator side of the virtual-JTAG debug-slave interface. Runs one scan per
// command: UIR, CDR, DR_WIDTH shift periods, UDR, RTI_TCKS idle periods, then
// returns the captured tdo word on a valid/ready response channel.
module jtag_debug_host_scan #(
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned TCK_DIV  = 2,
  parameter int unsigned RTI_TCKS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int unsigned DivW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int unsigned BitW = $clog2(DR_WIDTH + 1);
  localparam int unsigned RtiW = $clog2(RTI_TCKS + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(TCK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DR_WIDTH - 1);
  localparam logic [RtiW-1:0] RtiLast = RtiW'(RTI_TCKS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StUir,
    StCdr,
    StShift,
    StUdr,
    StRti,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                phase_q, phase_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [RtiW-1:0]     rti_q, rti_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;

  logic in_scan;
  logic half_end;
  logic tck_rise;
  logic period_end;

  // tck only toggles while a scan is in flight; IDLE and RESP keep it low.
  assign in_scan    = (state_q != StIdle) && (state_q != StResp);
  assign half_end   = (div_q == DivLast);
  assign tck_rise   = in_scan && !phase_q && half_end;
  assign period_end = in_scan && phase_q && half_end;

  // State and datapath registers; reset aborts any scan in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      rti_q   <= '0;
      shift_q <= '0;
      cap_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      rti_q   <= rti_d;
      shift_q <= shift_d;
      cap_q   <= cap_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, tck divider and shift/capture datapath.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    rti_d   = rti_q;
    shift_d = shift_q;
    cap_d   = cap_q;
    ir_d    = ir_q;

    if (in_scan) begin
      if (half_end) begin
        div_d   = '0;
        phase_d = !phase_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ir_d    = cmd_ir;
          shift_d = cmd_dr;
          div_d   = '0;
          phase_d = 1'b0;
          state_d = StUir;
        end
      end
      StUir: begin
        if (period_end) state_d = StCdr;
      end
      StCdr: begin
        if (period_end) begin
          bit_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // tdo is sampled on the edge that raises tck, mirroring the slave.
        if (tck_rise) cap_d = {tdo, cap_q[DR_WIDTH-1:1]};
        if (period_end) begin
          shift_d = {1'b0, shift_q[DR_WIDTH-1:1]};
          if (bit_q == BitLast) begin
            state_d = StUdr;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StUdr: begin
        if (period_end) begin
          rti_d   = '0;
          state_d = StRti;
        end
      end
      StRti: begin
        if (period_end) begin
          if (rti_q == RtiLast) begin
            state_d = StResp;
          end else begin
            rti_d = rti_q + 1'b1;
          end
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes decode straight from the state register, so they only move on
  // the edge that starts a low half and are stable across each tck period.
  always_comb begin
    vs_uir         = (state_q == StUir);
    vs_cdr         = (state_q == StCdr);
    vs_sdr         = (state_q == StShift);
    vs_udr         = (state_q == StUdr);
    jtag_state_rti = (state_q == StRti);
    tdi            = (state_q == StShift) && shift_q[0];
    cmd_ready      = (state_q == StIdle);
    rsp_valid      = (state_q == StResp);
  end

  assign tck    = phase_q;
  assign rsp_dr = cap_q;
  assign ir_in  = ir_q;

endmodule

// File: tb/tb_jtag_debug_host_scan.sv
module tb_jtag_debug_host_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-configuration instance
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_ir = '0;
  logic [37:0] cmd_dr = '0;
  logic        rsp_ready = 1'b0;
  logic        cmd_ready, rsp_valid, tck, tdi, tdo;
  logic [37:0] rsp_dr;
  logic [1:0]  ir_in;
  logic        vs_uir, vs_cdr, vs_sdr, vs_udr, rti;

  // TCK_DIV=1, RTI_TCKS=3 instance
  logic        v_reset = 1'b1;
  logic        v_cmd_valid = 1'b0;
  logic [1:0]  v_cmd_ir = '0;
  logic [37:0] v_cmd_dr = '0;
  logic        v_rsp_ready = 1'b0;
  logic        v_cmd_ready, v_rsp_valid, v_tck, v_tdi, v_tdo;
  logic [37:0] v_rsp_dr;
  logic [1:0]  v_ir_in;
  logic        v_uir, v_cdr, v_sdr, v_udr, v_rti;

  jtag_debug_host_scan #(.IR_WIDTH(2), .DR_WIDTH(38), .TCK_DIV(2), .RTI_TCKS(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dr(rsp_dr), .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .jtag_state_rti(rti)
  );

  jtag_debug_host_scan #(.IR_WIDTH(2), .DR_WIDTH(38), .TCK_DIV(1), .RTI_TCKS(3)) dut_v (
    .clk(clk), .reset(v_reset), .cmd_valid(v_cmd_valid), .cmd_ready(v_cmd_ready),
    .cmd_ir(v_cmd_ir), .cmd_dr(v_cmd_dr), .rsp_valid(v_rsp_valid), .rsp_ready(v_rsp_ready),
    .rsp_dr(v_rsp_dr), .tck(v_tck), .tdi(v_tdi), .tdo(v_tdo), .ir_in(v_ir_in),
    .vs_uir(v_uir), .vs_cdr(v_cdr), .vs_sdr(v_sdr), .vs_udr(v_udr),
    .jtag_state_rti(v_rti)
  );

  // Behavioural slaves: 38-bit tck-clocked shift registers, tdo = bit 0.
  logic        load = 1'b0, v_load = 1'b0;
  logic [37:0] pre = '0, v_pre = '0;
  logic [37:0] sr, v_sr;

  always @(posedge tck or posedge load) begin
    if (load) sr <= pre;
    else if (vs_sdr) sr <= {tdi, sr[37:1]};
  end
  always @(posedge v_tck or posedge v_load) begin
    if (v_load) v_sr <= v_pre;
    else if (v_sdr) v_sr <= {v_tdi, v_sr[37:1]};
  end
  assign tdo   = sr[0];
  assign v_tdo = v_sr[0];

  // Observation mux: sel picks which instance the tasks look at.
  logic        sel = 1'b0;
  wire         m_tck       = sel ? v_tck : tck;
  wire         m_tdi       = sel ? v_tdi : tdi;
  wire         m_cmd_ready = sel ? v_cmd_ready : cmd_ready;
  wire         m_rsp_valid = sel ? v_rsp_valid : rsp_valid;
  wire [37:0]  m_rsp_dr    = sel ? v_rsp_dr : rsp_dr;
  wire [1:0]   m_ir        = sel ? v_ir_in : ir_in;
  wire [37:0]  m_sr        = sel ? v_sr : sr;
  wire [4:0]   m_code      = sel ? {v_rti, v_udr, v_sdr, v_cdr, v_uir}
                                 : {rti, vs_udr, vs_sdr, vs_cdr, vs_uir};

  int passes = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: strobe one-hot {rti,udr,sdr,cdr,uir} for tck period p.
  function automatic logic [4:0] exp_code(input int p, input int rti_tcks);
    if (p == 0) return 5'b00001;
    if (p == 1) return 5'b00010;
    if (p < 40) return 5'b00100;
    if (p == 40) return 5'b01000;
    if (p < 41 + rti_tcks) return 5'b10000;
    return 5'b00000;
  endfunction

  // Reference: tdi during tck period p is bit p-2 of the command word.
  function automatic logic exp_tdi(input int p, input logic [37:0] dr);
    if (p >= 2 && p < 40) return dr[p-2];
    return 1'b0;
  endfunction

  function automatic logic [37:0] rnd38();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  task automatic drive(input logic valid, input logic [1:0] ir, input logic [37:0] dr);
    if (sel) begin
      v_cmd_valid = valid; v_cmd_ir = ir; v_cmd_dr = dr;
    end else begin
      cmd_valid = valid; cmd_ir = ir; cmd_dr = dr;
    end
  endtask

  task automatic set_ready(input logic r);
    if (sel) v_rsp_ready = r;
    else rsp_ready = r;
  endtask

  task automatic preload(input logic [37:0] val);
    if (sel) begin
      v_pre = val; v_load = 1'b1; #1 v_load = 1'b0;
    end else begin
      pre = val; load = 1'b1; #1 load = 1'b0;
    end
  endtask

  // One full scan on the selected instance with cycle-exact checking.
  task automatic run_scan(input logic [1:0] ir, input logic [37:0] dr, input logic [37:0] pv,
                          input int hold, input bit early);
    int d, rt, n, k, rti_cnt;
    d = sel ? 1 : 2;
    rt = sel ? 3 : 1;
    n = 2 * d * (38 + 3 + rt);
    rti_cnt = 0;
    preload(pv);
    @(negedge clk);
    set_ready(early);
    chk("ready_before_cmd", m_cmd_ready, 1);
    drive(1'b1, ir, dr);
    @(posedge clk);
    #1;
    drive(1'b0, 2'b00, 38'h0);
    k = 0;
    while (!m_rsp_valid && k <= n + 8) begin
      chk("scan_cycle", {m_tck, m_code, m_tdi, m_ir, m_cmd_ready},
          {((k % (2 * d)) >= d), exp_code(k / (2 * d), rt), exp_tdi(k / (2 * d), dr), ir, 1'b0});
      if (m_code == 5'b10000) rti_cnt++;
      @(posedge clk);
      #1;
      k++;
    end
    chk("rsp_latency", k, n);
    chk("rti_clks", rti_cnt, 2 * d * rt);
    chk("rsp_dr", m_rsp_dr, pv);
    chk("slave_after_scan", m_sr, dr);
    chk("resp_quiet", {m_tck, m_code, m_tdi, m_cmd_ready, m_ir}, {9'b0, ir});
    if (early) begin
      @(posedge clk);
      #1;
      chk("early_release", {m_rsp_valid, m_cmd_ready}, 2'b01);
      set_ready(1'b0);
    end else begin
      for (int h = 0; h < hold; h++) begin
        if (h == 10) drive(1'b1, ~ir, ~dr);
        if (h == 20) drive(1'b0, 2'b00, 38'h0);
        @(posedge clk);
        #1;
        chk("resp_hold", {m_rsp_valid, m_rsp_dr, m_tck, m_cmd_ready, m_code, m_ir},
            {1'b1, pv, 1'b0, 1'b0, 5'b0, ir});
      end
      drive(1'b0, 2'b00, 38'h0);
      set_ready(1'b1);
      @(posedge clk);
      #1;
      chk("handshake", {m_rsp_valid, m_cmd_ready}, 2'b01);
      set_ready(1'b0);
    end
  endtask

  initial begin
    logic prev_tck;
    int   rises, k, seen;

    // 1. Reset values
    reset = 1'b1; v_reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; v_reset = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      chk("reset_state", {cmd_ready, rsp_valid, tck, tdi, rsp_dr, ir_in, rti, vs_udr, vs_sdr,
          vs_cdr, vs_uir}, {1'b1, 3'b0, 38'h0, 2'b0, 5'b0});
      @(posedge clk);
      #1;
    end
    chk("reset_state_v", {v_cmd_ready, v_rsp_valid, v_tck, v_rsp_dr, v_ir_in, v_rti},
        {1'b1, 2'b0, 38'h0, 2'b0, 1'b0});

    // 2/3. Loopback with fixed words, full strobe sequence
    sel = 1'b0;
    run_scan(2'b01, 38'h15_1234_5678, 38'h2A_5A5A_5A5A, 0, 1'b0);

    // 4. Backpressure with a second command offered while the response waits
    run_scan(2'b10, rnd38(), rnd38(), 50, 1'b0);
    run_scan(2'b11, rnd38(), rnd38(), 0, 1'b0);

    // rsp_ready already high when RESP is entered
    run_scan(2'($urandom_range(3)), rnd38(), rnd38(), 0, 1'b1);

    // Random scans
    for (int i = 0; i < 3; i++)
      run_scan(2'($urandom_range(3)), rnd38(), rnd38(), int'($urandom_range(5)), 1'b0);

    // 5. Reset mid-shift at bit 17 (tck period 19)
    preload(rnd38());
    @(negedge clk);
    drive(1'b1, 2'b10, rnd38());
    @(posedge clk);
    #1;
    drive(1'b0, 2'b00, 38'h0);
    rises = 0; k = 0; prev_tck = 1'b0;
    while (rises < 20 && k < 400) begin
      @(posedge clk);
      #1;
      k++;
      if (tck && !prev_tck) rises++;
      prev_tck = tck;
    end
    chk("reached_bit17", {rises[7:0], vs_sdr, tck}, {8'd20, 2'b11});
    #2 reset = 1'b1;
    #1;
    chk("async_abort", {tck, tdi, rti, vs_udr, vs_sdr, vs_cdr, vs_uir, rsp_valid, cmd_ready, ir_in},
        {9'b0_0000_0001, 2'b00});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || tck || (m_code != 5'b0)) seen++;
    end
    chk("no_activity_after_abort", seen, 0);
    run_scan(2'b01, rnd38(), rnd38(), 3, 1'b0);

    // 6. Parameter variant: TCK_DIV=1, RTI_TCKS=3
    sel = 1'b1;
    run_scan(2'b01, 38'h15_1234_5678, 38'h2A_5A5A_5A5A, 0, 1'b0);
    run_scan(2'($urandom_range(3)), rnd38(), rnd38(), 12, 1'b0);
    run_scan(2'($urandom_range(3)), rnd38(), rnd38(), 0, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/jtag_debug_host_scan.md
Name: jtag_debug_host_scan

Overview:
- Initiator end of the virtual-JTAG debug-slave interface. Used for simulation and on-chip self-test of the Nios II debug slave.
- Accepts one scan command: an IR value plus a DR word. It generates tck, the virtual state strobes (uir/cdr/sdr/udr/rti) and tdi, and captures tdo.
- Returns the captured DR word through a valid/ready response channel.
- Sits in place of the sld_virtual_jtag_basic hub, driving the debug slave's tck-domain logic.

Parameters:
- IR_WIDTH, 2, width of the instruction presented on ir_in.
- DR_WIDTH, 38, number of bits shifted per scan; equals the debug slave's sr width.
- TCK_DIV, 2, clk cycles per tck half-period (≥1).
- RTI_TCKS, 1, tck periods spent in run-test-idle after update (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  scan command offered.
- cmd_ready  out  1  block idle; command accepted when cmd_valid&cmd_ready.
- cmd_ir  in  IR_WIDTH  instruction to load.
- cmd_dr  in  DR_WIDTH  data shifted in, LSB first.
- rsp_valid  out  1  captured word available.
- rsp_ready  in  1  response consumed.
- rsp_dr  out  DR_WIDTH  captured tdo bits, bit0 = first bit out.
- tck  out  1  generated test clock.
- tdi  out  1  serial data to slave.
- tdo  in  1  serial data from slave.
- ir_in  out  IR_WIDTH  instruction to slave.
- vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti  out  1 each  virtual state strobes.

Behaviour:
- Reset is asynchronous and active-high. It clears:
  - state to IDLE, tck=0, tdi=0, ir_in=0, all strobes=0;
  - cmd_ready=1, rsp_valid=0, rsp_dr=0.
- Reset mid-scan aborts immediately: no response is produced and no partial strobe is left asserted.
- States: IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP.
- tck period:
  - Each tck period is 2*TCK_DIV clk cycles: low half first, then high half.
  - tck is held 0 in IDLE and RESP.
  - A divide counter 0..TCK_DIV-1 plus a phase bit time the halves.
- State outputs (strobes, ir_in, tdi) change only on the clk edge that begins a low half. They are stable across the whole tck period.
- Acceptance (IDLE, cmd_valid=1):
  - Latch cmd_ir into ir_in and cmd_dr into the shift register.
  - cmd_ready drops on the next cycle.
  - Go to UIR.
- UIR, 1 tck period: vs_uir=1. Then CDR.
- CDR, 1 tck period: vs_cdr=1. Then SHIFT with bit counter=0.
- SHIFT, DR_WIDTH tck periods, vs_sdr=1:
  - tdi = shift_reg[0] for the whole period.
  - On the clk edge where tck rises, tdo is sampled into capture: cap <= {tdo, cap[DR_WIDTH-1:1]}.
  - At period end, shift_reg shifts right by one.
  - After period DR_WIDTH-1, go to UDR.
  - tdi returns to 0 outside SHIFT.
- UDR, 1 tck period: vs_udr=1. Then RTI.
- RTI, RTI_TCKS periods: jtag_state_rti=1. Then RESP.
- RESP:
  - rsp_valid=1 and rsp_dr=cap, both held stable until rsp_ready=1.
  - On handshake: rsp_valid=0 next cycle, go to IDLE, cmd_ready=1 the same cycle.
  - If rsp_ready is already 1 on entry, the block spends exactly one cycle in RESP.
- Latency: rsp_valid rises exactly 2*TCK_DIV*(DR_WIDTH+3+RTI_TCKS) clk cycles after the accepting edge. With defaults this is 168.
- Throughput: there is no command pipelining. A new command is never accepted while rsp_valid=1. cmd_valid during a busy scan is ignored, not lost; the source holds it.
- ir_in holds its last value after the scan, including in IDLE, until the next acceptance or reset.
- At most one strobe among vs_uir/vs_cdr/vs_sdr/vs_udr/jtag_state_rti is 1 at any time.
- Wrap-around: the bit counter is sized clog2(DR_WIDTH+1). It is never compared beyond DR_WIDTH-1.

Test Plan:
1. Reset values:
   - Stimulus: assert reset for 3 cycles, release.
   - Response: cmd_ready=1, rsp_valid=0, tck=0, all strobes 0.
   - Hold rsp_ready=0 for 20 cycles: outputs must not change.
2. Loopback:
   - Stimulus: tdo tied to a behavioural 38-bit tck shift model preloaded with 0x2A_5A5A_5A5A; cmd_ir=2'b01, cmd_dr=0x15_1234_5678.
   - Response: rsp_dr=0x2A_5A5A_5A5A; model holds 0x15_1234_5678 after scan; rsp_valid at exactly cycle 168; ir_in=2'b01 throughout.
3. Strobe sequence:
   - Check: per-tck-period strobe order is uir(1), cdr(1), sdr(38), udr(1), rti(1); one-hot at all times; tdi stable through every high half.
4. Backpressure:
   - Stimulus: hold rsp_ready=0 for 50 cycles after rsp_valid; pulse cmd_valid with a second command.
   - Response: rsp_dr stable, no second acceptance; after rsp_ready=1, second scan starts and produces correct data.
5. Reset mid-SHIFT:
   - Stimulus: assert reset at bit 17.
   - Response: all strobes and tck go to 0 asynchronously; no rsp_valid; the next command completes normally.
6. Parameter variant:
   - Config: TCK_DIV=1, RTI_TCKS=3, DR_WIDTH=38.
   - Response: tck period of 2 clk; rsp_valid at cycle 88; jtag_state_rti high for 6 clk.
